// File: rtl/jt5205_tgen.sv
// jt5205_tgen
// Sample-rate timing generator for a bank of MSM5205-style ADPCM channels.
// Each channel divides the master clock tick (cen) by a limit chosen from the
// S pins (96/64/48 ticks per sample) or from a per-channel custom divider. It
// produces a sample strobe, an opposite-phase strobe at the half period, their
// OR as a double-rate strobe, and a registered VCK pin image.
//
// Parameters
//   CH       number of independent channels (1..8)
//   CW       counter / divider width per channel (7..12)
//   VCLK_CEN 1: vclk_o clears on every clk with cen low (one-clk VCK pulse)
//            0: vclk_o only moves at wrap (high) and half point (low)
//
// Ports
//   clk       system clock, all state on rising edge
//   rst_n     asynchronous active-low reset
//   cen       master clock tick
//   sel       per-channel S pins, channel i on sel[2i+1:2i] (3 = stopped)
//   cust_en   per-channel custom divider enable, overrides sel
//   cust_div  per-channel custom limit, channel i on [CW*i +: CW]
//   sync      one-cycle restart of every running channel
//   cen_lo    sample-rate strobe
//   cenb_lo   sample-rate strobe, half a period later
//   cen_mid   double-rate strobe (cen_lo | cenb_lo)
//   vclk_o    registered VCK pin
module jt5205_tgen #(
  parameter int CH       = 2,
  parameter int CW       = 8,
  parameter int VCLK_CEN = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cen,
  input  logic [2*CH-1:0]    sel,
  input  logic [CH-1:0]      cust_en,
  input  logic [CW*CH-1:0]   cust_div,
  input  logic               sync,
  output logic [CH-1:0]      cen_lo,
  output logic [CH-1:0]      cenb_lo,
  output logic [CH-1:0]      cen_mid,
  output logic [CH-1:0]      vclk_o
);

  localparam logic [CW-1:0] LIM_96  = CW'(95);
  localparam logic [CW-1:0] LIM_64  = CW'(63);
  localparam logic [CW-1:0] LIM_48  = CW'(47);
  localparam logic [CW-1:0] LIM_MIN = CW'(1);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [CW-1:0] cnt;
    logic [CW-1:0] lim_q;
    logic [CW-1:0] nxt_lim;
    logic [CW-1:0] div_i;
    logic [1:0]    sel_i;
    logic          stopped;
    logic          pre;
    logic          preb;
    logic          vclk;
    logic          at_wrap;
    logic          at_half;

    assign sel_i = sel[2*i +: 2];
    assign div_i = cust_div[CW*i +: CW];

    // Limit that the channel will adopt at its next wrap, sync or stop.
    // A zero custom divider is clamped to 1 so the counter never locks at 0.
    // sel=3 without the custom divider stops the channel; the limit parked
    // in lim_q while stopped is the power-on 96-tick value.
    always_comb begin
      nxt_lim = LIM_96;
      stopped = 1'b0;
      if (cust_en[i]) begin
        nxt_lim = (div_i == '0) ? LIM_MIN : div_i;
      end else begin
        case (sel_i)
          2'd0:    nxt_lim = LIM_96;
          2'd1:    nxt_lim = LIM_64;
          2'd2:    nxt_lim = LIM_48;
          default: begin
            nxt_lim = LIM_96;
            stopped = 1'b1;
          end
        endcase
      end
    end

    // Since lim_q is never 0, lim_q>>1 is always below lim_q and the wrap
    // and half points cannot coincide.
    assign at_wrap = (cnt == lim_q);
    assign at_half = (cnt == (lim_q >> 1));

    // Per-channel divider. Priority: reset, stop, sync, then cen events.
    // The active limit lim_q is only reloaded at points where cnt restarts,
    // so a divider change never truncates or stretches the running period.
    // pre/preb are left alone on non-cen cycles so the strobes, which are
    // gated with cen, fire on the first tick after the flag is raised.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt   <= '0;
        lim_q <= LIM_96;
        pre   <= 1'b0;
        preb  <= 1'b0;
        vclk  <= 1'b0;
      end else if (stopped || sync) begin
        cnt   <= '0;
        lim_q <= nxt_lim;
        pre   <= 1'b0;
        preb  <= 1'b0;
        vclk  <= 1'b0;
      end else if (cen) begin
        if (at_wrap) begin
          cnt   <= '0;
          lim_q <= nxt_lim;
          pre   <= 1'b1;
          preb  <= 1'b0;
          vclk  <= 1'b1;
        end else begin
          cnt  <= cnt + CW'(1);
          pre  <= 1'b0;
          preb <= at_half;
          if (at_half) begin
            vclk <= 1'b0;
          end
        end
      end else if (VCLK_CEN != 0) begin
        vclk <= 1'b0;
      end
    end

    // Strobes are plain gates of the registered flags with the tick.
    assign cen_lo[i]  = pre & cen;
    assign cenb_lo[i] = preb & cen;
    assign cen_mid[i] = (pre | preb) & cen;
    assign vclk_o[i]  = vclk;
  end

endmodule

// File: tb/tb_jt5205_tgen.sv
// tb_jt5205_tgen
// Scoreboard bench for jt5205_tgen. Two instances share all inputs and differ
// only in VCLK_CEN. The stimulus process drives inputs just after each rising
// edge, pushes the outputs it expects for that cycle, then advances a
// reference model that thinks in terms of "ticks elapsed in the current
// sample period" and "last event seen". A monitor pops one entry per falling
// edge and compares it with both instances.
module tb_jt5205_tgen;

  localparam int CH = 2;
  localparam int CW = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cen;
  logic [2*CH-1:0]    sel;
  logic [CH-1:0]      cust_en;
  logic [CW*CH-1:0]   cust_div;
  logic               sync;
  logic [CH-1:0]      a_cen_lo, a_cenb_lo, a_cen_mid, a_vclk;
  logic [CH-1:0]      b_cen_lo, b_cenb_lo, b_cen_mid, b_vclk;

  // Values the test phases want applied on the next driven cycle
  logic [2*CH-1:0]    d_sel;
  logic [CH-1:0]      d_cust_en;
  logic [CW*CH-1:0]   d_cust_div;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  jt5205_tgen #(.CH(CH), .CW(CW), .VCLK_CEN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .cen(cen), .sel(sel), .cust_en(cust_en),
    .cust_div(cust_div), .sync(sync), .cen_lo(a_cen_lo), .cenb_lo(a_cenb_lo),
    .cen_mid(a_cen_mid), .vclk_o(a_vclk)
  );

  jt5205_tgen #(.CH(CH), .CW(CW), .VCLK_CEN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .cen(cen), .sel(sel), .cust_en(cust_en),
    .cust_div(cust_div), .sync(sync), .cen_lo(b_cen_lo), .cenb_lo(b_cenb_lo),
    .cen_mid(b_cen_mid), .vclk_o(b_vclk)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_NONE, EV_WRAP, EV_HALF} ev_t;

  typedef struct packed {
    logic [CH-1:0] lo;
    logic [CH-1:0] lob;
    logic [CH-1:0] mid;
    logic [CH-1:0] va;
    logic [CH-1:0] vb;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: ticks elapsed in the period, period length in ticks,
  // the event the last tick produced, and the VCK level for each variant.
  int   pos[CH];
  int   plen[CH];
  ev_t  ev[CH];
  logic vck_a[CH];
  logic vck_b[CH];

  // Divider value the channel would use for its next period.
  function automatic int refLimit(input logic ce, input logic [1:0] s, input int div);
    if (ce) return (div == 0) ? 1 : div;
    case (s)
      2'd0:    return 95;
      2'd1:    return 63;
      2'd2:    return 47;
      default: return 95;
    endcase
  endfunction

  // Drive one clk cycle of inputs, record what the DUT must show during
  // that cycle, then advance the model across the next rising edge.
  task automatic applyStimulus(input logic r, input logic c, input logic s);
    exp_t e;
    int   lim;
    logic stop;
    @(posedge clk);
    #1;
    rst_n    = r;
    cen      = c;
    sync     = s;
    sel      = d_sel;
    cust_en  = d_cust_en;
    cust_div = d_cust_div;
    cyc++;
    if (!r) begin
      for (int i = 0; i < CH; i++) begin
        pos[i]   = 0;
        plen[i]  = 96;
        ev[i]    = EV_NONE;
        vck_a[i] = 1'b0;
        vck_b[i] = 1'b0;
      end
    end
    e = '0;
    for (int i = 0; i < CH; i++) begin
      e.lo[i]  = c && (ev[i] == EV_WRAP);
      e.lob[i] = c && (ev[i] == EV_HALF);
      e.mid[i] = c && (ev[i] != EV_NONE);
      e.va[i]  = vck_a[i];
      e.vb[i]  = vck_b[i];
    end
    exp_q.push_back(e);
    if (r) begin
      for (int i = 0; i < CH; i++) begin
        lim  = refLimit(d_cust_en[i], d_sel[2*i +: 2], int'(d_cust_div[CW*i +: CW]));
        stop = !d_cust_en[i] && (d_sel[2*i +: 2] == 2'd3);
        if (stop || s) begin
          pos[i]   = 0;
          plen[i]  = lim + 1;
          ev[i]    = EV_NONE;
          vck_a[i] = 1'b0;
          vck_b[i] = 1'b0;
        end else if (c) begin
          if (pos[i] == plen[i] - 1) begin
            pos[i]   = 0;
            plen[i]  = lim + 1;
            ev[i]    = EV_WRAP;
            vck_a[i] = 1'b1;
            vck_b[i] = 1'b1;
          end else if (pos[i] == (plen[i] - 1) / 2) begin
            pos[i]++;
            ev[i]    = EV_HALF;
            vck_a[i] = 1'b0;
            vck_b[i] = 1'b0;
          end else begin
            pos[i]++;
            ev[i] = EV_NONE;
          end
        end else begin
          vck_a[i] = 1'b0;
        end
      end
    end
  endtask

  // Run n cycles; cen on every cdiv-th cycle, or randomly (3 in 4) if cdiv=0.
  task automatic runCycles(input int n, input int cdiv);
    logic c;
    for (int k = 0; k < n; k++) begin
      if (cdiv == 0) c = ($urandom_range(3) != 0);
      else           c = ((cyc % cdiv) == 0);
      applyStimulus(1'b1, c, 1'b0);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if ({a_cen_lo, a_cenb_lo, a_cen_mid} !== {e.lo, e.lob, e.mid}) begin
      errors++;
      $display("[TB] FAIL strobes_a t=%0t got %b expected %b", $time,
               {a_cen_lo, a_cenb_lo, a_cen_mid}, {e.lo, e.lob, e.mid});
    end
    checks++;
    if ({b_cen_lo, b_cenb_lo, b_cen_mid} !== {e.lo, e.lob, e.mid}) begin
      errors++;
      $display("[TB] FAIL strobes_b t=%0t got %b expected %b", $time,
               {b_cen_lo, b_cenb_lo, b_cen_mid}, {e.lo, e.lob, e.mid});
    end
    checks++;
    if (a_vclk !== e.va) begin
      errors++;
      $display("[TB] FAIL vclk_cen1 t=%0t got %b expected %b", $time, a_vclk, e.va);
    end
    checks++;
    if (b_vclk !== e.vb) begin
      errors++;
      $display("[TB] FAIL vclk_cen0 t=%0t got %b expected %b", $time, b_vclk, e.vb);
    end
  endtask

  // Monitor: one expected entry per cycle, compared away from the rising edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    cen        = 1'b0;
    sync       = 1'b0;
    sel        = '0;
    cust_en    = '0;
    cust_div   = '0;
    d_sel      = 4'b1000;
    d_cust_en  = '0;
    d_cust_div = '0;

    $display("[TB] reset");
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b1, 1'b0);

    $display("[TB] ch0 sel=0, ch1 sel=2, cen every clk");
    runCycles(300, 1);

    $display("[TB] sel=1, cen every 4th clk");
    d_sel = 4'b0101;
    applyStimulus(1'b1, 1'b0, 1'b1);
    runCycles(800, 4);

    $display("[TB] custom divider 1 then 0 on ch0");
    d_cust_en  = 2'b01;
    d_cust_div = {8'd0, 8'd1};
    runCycles(40, 2);
    d_cust_div = {8'd0, 8'd0};
    runCycles(40, 1);
    d_cust_en  = 2'b00;

    $display("[TB] sel 0 -> 2 ten ticks into a period");
    d_sel = 4'b0000;
    applyStimulus(1'b1, 1'b1, 1'b1);
    runCycles(10, 1);
    d_sel = 4'b1010;
    runCycles(200, 1);

    $display("[TB] stop mid-period then resume");
    d_sel = 4'b0000;
    applyStimulus(1'b1, 1'b1, 1'b1);
    runCycles(30, 1);
    d_sel = 4'b1111;
    runCycles(5, 1);
    d_sel = 4'b0000;
    runCycles(200, 1);

    $display("[TB] sync and reset pulse mid-period");
    runCycles(50, 1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    runCycles(70, 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    runCycles(200, 1);

    $display("[TB] random traffic");
    for (int k = 0; k < 20000; k++) begin
      logic r, c, s;
      if ($urandom_range(199) == 0) d_sel      = 4'($urandom);
      if ($urandom_range(399) == 0) d_cust_en  = 2'($urandom);
      if ($urandom_range(149) == 0) begin
        for (int i = 0; i < CH; i++)
          d_cust_div[CW*i +: CW] = ($urandom_range(1) != 0) ? 8'($urandom_range(20))
                                                           : 8'($urandom);
      end
      c = ($urandom_range(3) != 0);
      s = ($urandom_range(499) == 0);
      r = ($urandom_range(2999) != 0);
      applyStimulus(r, c, s);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
